// File: rtl/div_unit.sv
// Multi-cycle restoring divider (signed/unsigned) with start/annul handshake.
// Optional macro DIV_BYZERO_FLAG_EN adds a registered divide-by-zero flag output.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
`ifdef DIV_BYZERO_FLAG_EN
    ,
    output logic               divzero_o
`endif
);

    // state      | meaning
    // DIV_FREE   | idle, waiting for an accepted start
    // DIV_BYZERO | divisor was zero, result forced to 0
    // DIV_ON     | one shift-subtract step per cycle, then sign fix-up
    // DIV_END    | result valid, held until start_i drops
    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
`ifdef DIV_BYZERO_FLAG_EN
    logic               divzero_q, divzero_d;
`endif

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitude datapath: the partial remainder never exceeds the divisor, so
    // the W-bit subtraction is exact whenever the trial value fits.
    always_comb begin
        abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        trial   = {rem_q, quo_q[WIDTH-1]};
        fits    = (trial >= {1'b0, dvs_q});
        rem_sub = trial[WIDTH-1:0] - dvs_q;
        quo_fix = negq_q ? -quo_q : quo_q;
        rem_fix = negr_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
        divzero_d = divzero_q;
`endif

        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    negq_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    negr_d  = signed_div_i & opdata1_i[WIDTH-1];
                    quo_d   = abs_a;
                    rem_d   = '0;
                    dvs_d   = abs_b;
                    cnt_d   = '0;
                    state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end

            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    result_d = '0;
                    state_d  = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end else begin
                    rem_d = fits ? rem_sub : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DIV_END: begin
                // Arriving from DIV_ON ready is already set; the zero-divisor
                // path raises it here, one cycle after entry.
                if (annul_i) begin
                    ready_d = 1'b0;
                    state_d = DIV_FREE;
`ifdef DIV_BYZERO_FLAG_EN
                    divzero_d = 1'b0;
`endif
                end else if (!ready_q) begin
                    ready_d = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                    divzero_d = 1'b1;
`endif
                end else if (!start_i) begin
                    ready_d = 1'b0;
                    state_d = DIV_FREE;
`ifdef DIV_BYZERO_FLAG_EN
                    divzero_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            divzero_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_BYZERO_FLAG_EN
            divzero_q <= divzero_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DIV_ON) || (state_q == DIV_BYZERO);
`ifdef DIV_BYZERO_FLAG_EN
    assign divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit at WIDTH=32 and WIDTH=8 against an arithmetic model.
// Honours DIV_BYZERO_FLAG_EN when defined.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        s32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, bsy32;

    logic        s8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, bsy8;

`ifdef DIV_BYZERO_FLAG_EN
    logic        dz32, dz8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) u_div32 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s32),
        .opdata1_i    (a32),
        .opdata2_i    (b32),
        .start_i      (st32),
        .annul_i      (an32),
        .result_o     (res32),
        .ready_o      (rdy32),
        .busy_o       (bsy32)
`ifdef DIV_BYZERO_FLAG_EN
        ,
        .divzero_o    (dz32)
`endif
    );

    div_unit #(.WIDTH(8)) u_div8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s8),
        .opdata1_i    (a8),
        .opdata2_i    (b8),
        .start_i      (st8),
        .annul_i      (an8),
        .result_o     (res8),
        .ready_o      (rdy8),
        .busy_o       (bsy8)
`ifdef DIV_BYZERO_FLAG_EN
        ,
        .divzero_o    (dz8)
`endif
    );

    // Reference: truncating integer division on w-bit operands, {rem, quo}.
    function automatic logic [63:0] model(input int w, input bit s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, mask;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return 64'(((r & mask) << w) | (q & mask));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op32(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        bit          byz;
        int          lat;
        exp = model(32, s, a, b);
        byz = (b == 32'd0);
        lat = byz ? 2 : 33;
        @(negedge clk);
        s32 = s; a32 = a; b32 = b; st32 = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                a32 = $urandom; b32 = $urandom; s32 = ~s;
            end
            check("busy32", 64'(bsy32), 64'(byz ? (k == 0) : (k <= 32)));
            check("ready32", 64'(rdy32), 64'(k >= lat));
        end
        check("result32", res32, exp);
`ifdef DIV_BYZERO_FLAG_EN
        check("divzero32", 64'(dz32), 64'(byz));
`endif
        @(posedge clk); #1;
        check("ready32_hold", 64'(rdy32), 64'd1);
        check("result32_hold", res32, exp);
        @(negedge clk);
        st32 = 1'b0;
        @(posedge clk); #1;
        check("ready32_drop", 64'(rdy32), 64'd0);
        check("busy32_drop", 64'(bsy32), 64'd0);
        check("result32_kept", res32, exp);
`ifdef DIV_BYZERO_FLAG_EN
        check("divzero32_drop", 64'(dz32), 64'd0);
`endif
    endtask

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] exp;
        bit          byz;
        int          lat;
        exp = model(8, s, {24'd0, a}, {24'd0, b});
        byz = (b == 8'd0);
        lat = byz ? 2 : 9;
        @(negedge clk);
        s8 = s; a8 = a; b8 = b; st8 = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
            end
            check("busy8", 64'(bsy8), 64'(byz ? (k == 0) : (k <= 8)));
            check("ready8", 64'(rdy8), 64'(k >= lat));
        end
        check("result8", 64'(res8), exp);
`ifdef DIV_BYZERO_FLAG_EN
        check("divzero8", 64'(dz8), 64'(byz));
`endif
        repeat (3) begin
            @(posedge clk); #1;
            check("ready8_hold", 64'(rdy8), 64'd1);
            check("result8_hold", 64'(res8), exp);
        end
        @(negedge clk);
        st8 = 1'b0;
        @(posedge clk); #1;
        check("ready8_drop", 64'(rdy8), 64'd0);
        check("result8_kept", 64'(res8), exp);
    endtask

    initial begin
        rst = 1'b0;
        s32 = 1'b0; st32 = 1'b0; an32 = 1'b0; a32 = '0; b32 = '0;
        s8  = 1'b0; st8  = 1'b0; an8  = 1'b0; a8  = '0; b8  = '0;

        #12;
        check("rst_result32", res32, 64'd0);
        check("rst_ready32", 64'(rdy32), 64'd0);
        check("rst_busy32", 64'(bsy32), 64'd0);
        check("rst_result8", 64'(res8), 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
        check("rst_divzero32", 64'(dz32), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        op32(1'b0, 32'd100, 32'd7);
        op32(1'b1, 32'hFFFF_FFF9, 32'd2);
        op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        op32(1'b0, 32'h0000_1234, 32'd0);
        op32(1'b1, 32'h0000_1234, 32'd0);

        // start and annul together in the idle state must not be accepted
        @(negedge clk);
        st32 = 1'b1; an32 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("annul_start_busy", 64'(bsy32), 64'd0);
            check("annul_start_ready", 64'(rdy32), 64'd0);
        end
        @(negedge clk);
        st32 = 1'b0; an32 = 1'b0;

        // cancel after the tenth step
        @(negedge clk);
        s32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        an32 = 1'b1;
        @(posedge clk); #1;
        check("annul_busy", 64'(bsy32), 64'd0);
        check("annul_ready", 64'(rdy32), 64'd0);
        @(negedge clk);
        an32 = 1'b0; st32 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (rdy32 !== 1'b0 || k == 39) check("annul_no_ready", 64'(rdy32), 64'd0);
        end
        op32(1'b0, 32'd9, 32'd3);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        s32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h77; st32 = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_result", res32, 64'd0);
        check("midrst_ready", 64'(rdy32), 64'd0);
        check("midrst_busy", 64'(bsy32), 64'd0);
        st32 = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_held", 64'(bsy32), 64'd0);
        #2 rst = 1'b1;
        op32(1'b0, 32'd100, 32'd7);

        op8(1'b0, 8'hFF, 8'h10);
        op8(1'b1, 8'h80, 8'hFF);
        op8(1'b1, 8'hF9, 8'h02);
        op8(1'b0, 8'h05, 8'h00);

        for (int i = 0; i < 6; i++) begin
            op32(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 31)));
        end
        for (int i = 0; i < 20; i++) begin
            op8(1'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL provide port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance.
REQ-005 SHALL provide port opdata1_i  input  WIDTH  dividend; sampled at start acceptance.
REQ-006 SHALL provide port opdata2_i  input  WIDTH  divisor; sampled at start acceptance.
REQ-007 SHALL provide port start_i  input  1  request; held high by EX until ready_o is seen.
REQ-008 SHALL provide port annul_i  input  1  cancel the current operation (flush/exception).
REQ-009 SHALL provide port result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
REQ-010 SHALL provide port ready_o  output  1  result_o valid; registered.
REQ-011 SHALL provide port busy_o  output  1  high in states DIV_ON and DIV_BYZERO; used for the EX stall request.

Function
REQ-012 SHALL implement the four states DIV_FREE, DIV_BYZERO, DIV_ON and DIV_END in a single FSM.
REQ-013 SHALL accept a start in DIV_FREE on a rising edge where start_i=1 and annul_i=0 (accepting edge E0), latching operands and mode.
REQ-014 SHALL, at E0, go to DIV_BYZERO if opdata2_i==0, else go to DIV_ON with its iteration counter cleared to 0.
REQ-015 SHALL, in DIV_BYZERO, go to DIV_END on the next edge with result_o = 0.
REQ-016 SHALL, in DIV_ON, perform exactly one restoring shift-subtract step per edge on magnitudes, one quotient bit per step, WIDTH steps in total.
REQ-017 SHALL enter DIV_END on the edge after the final step, so that ready_o is high after edge E(WIDTH+1) (33 edges for WIDTH=32), and no earlier.
REQ-018 SHALL, for signed mode, divide the absolute values, negate the quotient when the dividend and divisor signs differ, and give the remainder the sign of the dividend (truncation toward zero).
REQ-019 SHALL, for signed most-negative / -1, return quotient = most-negative value (wraps) and remainder 0, with no trap.
REQ-020 SHALL, in DIV_END, hold ready_o=1 and result_o stable until start_i=0, then return to DIV_FREE with ready_o=0 and result_o held.
REQ-021 SHALL, when annul_i=1 in DIV_ON, DIV_BYZERO or DIV_END, return to DIV_FREE on the next edge with ready_o=0 and the partial result discarded.
REQ-022 SHALL ignore start_i in any state other than DIV_FREE, and SHALL ignore operand changes after E0.
REQ-023 SHALL, when start_i=1 and annul_i=1 on the same edge in DIV_FREE, not accept the start and stay in DIV_FREE.

Reset
REQ-024 SHALL, while rst=0 regardless of clk, force the state to DIV_FREE, result_o=0, ready_o=0, busy_o=0, the counter to 0 and the datapath registers to 0.
REQ-025 SHALL abandon any operation in progress when reset is applied mid-operation, and SHALL accept a new start on the first edge after rst returns to 1.

Configuration
REQ-026 SHALL recognise macro DIV_BYZERO_FLAG_EN.
REQ-027 SHALL, with DIV_BYZERO_FLAG_EN defined, add port divzero_o (output, 1 bit, registered, reset 0), high exactly while ready_o=1 for an operation that passed through DIV_BYZERO.
REQ-028 SHALL, without DIV_BYZERO_FLAG_EN, have no divzero_o port, with all other behaviour identical.

Verification
REQ-029 SHALL cover: WIDTH=32, unsigned 100/7 -> result_o={32'd2, 32'd14}, ready_o high after E33, busy_o high for E0..E32.
REQ-030 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 SHALL cover: divisor 0, dividend 0x1234 -> ready_o high after E2, result_o=0, and divzero_o=1 when DIV_BYZERO_FLAG_EN is defined.
REQ-032 SHALL cover: annul_i pulsed after the 10th step -> ready_o never rises and state is DIV_FREE; the next start of 9/3 yields quotient 3, remainder 0.
REQ-033 SHALL cover: rst driven low mid-DIV_ON, asynchronously between edges -> all outputs 0 immediately; start after release behaves per REQ-029.
REQ-034 SHALL cover: WIDTH=8, unsigned 0xFF/0x10 -> result_o={8'h0F, 8'h0F}, ready_o high after E9; ready_o holds until start_i drops.
